// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sfx_sequencer
//  Purpose  : Control stage for the SN76477 sound core. A trigger plays a
//             canned effect: a ROM sequence of timed steps, each driving the
//             SN76477 parameter inputs with an optional linear VCO sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module sfx_sequencer #(
    parameter int TICK_DIV  = 25000,  // clk cycles per sequencer tick
    parameter int LASER_DUR = 80      // laser step length in ticks (1..1023)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [1:0]  effect_sel,
    output logic [11:0] lfo_freq,
    output logic [11:0] noise_freq,
    output logic [11:0] vco_freq,
    output logic        vco_select,
    output logic        noise_select,
    output logic [3:0]  lfo_shift,
    output logic [2:0]  mixer,
    output logic        gate,
    output logic        busy,
    output logic        done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] c_tick_last = TW'(TICK_DIV - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_play = 1'b1;

    logic [0:0]    r_state, w_state_next;
    logic [TW-1:0] r_tick_cnt;
    logic [9:0]    r_dur_cnt;
    logic [1:0]    r_step;
    logic [1:0]    r_effect;
    logic [9:0]    r_delta;
    logic          r_last;
    logic          r_done;

    logic          w_tick, w_load, w_sweep, w_finish;
    logic [1:0]    w_rom_eff, w_rom_step;

    // ROM step fields
    logic [11:0]   w_rom_vco, w_rom_noise, w_rom_lfo;
    logic [9:0]    w_rom_delta, w_rom_dur;
    logic          w_rom_vsel, w_rom_nsel, w_rom_last;
    logic [3:0]    w_rom_shift;
    logic [2:0]    w_rom_mix;

    logic signed [13:0] w_vco_sum;
    logic [11:0]        w_vco_sat;

    assign w_tick = (r_tick_cnt == c_tick_last);

    // A trigger always addresses step 0 of the new effect; otherwise the ROM
    // looks one step ahead so the next step can load on the ending tick.
    assign w_rom_eff  = trigger ? effect_sel : r_effect;
    assign w_rom_step = trigger ? 2'd0 : (r_step + 2'd1);

    // Effect ROM: (vco, delta, noise, lfo, vsel, nsel, shift, mix, dur, last)
    always_comb begin
        w_rom_vco   = 12'd0;
        w_rom_delta = 10'd0;
        w_rom_noise = 12'd0;
        w_rom_lfo   = 12'd0;
        w_rom_vsel  = 1'b0;
        w_rom_nsel  = 1'b0;
        w_rom_shift = 4'd0;
        w_rom_mix   = 3'd0;
        w_rom_dur   = 10'd1;
        w_rom_last  = 1'b1;
        case ({w_rom_eff, w_rom_step})
            4'b00_00: begin  // laser
                w_rom_vco   = 12'd800;
                w_rom_delta = 10'h3F8;  // -8
                w_rom_mix   = 3'd1;
                w_rom_dur   = 10'(LASER_DUR);
            end
            4'b01_00: begin  // explosion, rumble
                w_rom_noise = 12'd90;
                w_rom_nsel  = 1'b1;
                w_rom_mix   = 3'd2;
                w_rom_dur   = 10'd200;
                w_rom_last  = 1'b0;
            end
            4'b01_01: begin  // explosion, tail
                w_rom_noise = 12'd200;
                w_rom_nsel  = 1'b1;
                w_rom_mix   = 3'd2;
                w_rom_dur   = 10'd300;
            end
            4'b10_00: begin  // siren
                w_rom_vco   = 12'd250;
                w_rom_lfo   = 12'd1000;
                w_rom_vsel  = 1'b1;
                w_rom_shift = 4'd1;
                w_rom_mix   = 3'd1;
                w_rom_dur   = 10'd500;
            end
            4'b11_00: begin  // blip, low
                w_rom_vco   = 12'd400;
                w_rom_mix   = 3'd1;
                w_rom_dur   = 10'd20;
                w_rom_last  = 1'b0;
            end
            4'b11_01: begin  // blip, mid
                w_rom_vco   = 12'd600;
                w_rom_mix   = 3'd1;
                w_rom_dur   = 10'd20;
                w_rom_last  = 1'b0;
            end
            4'b11_10: begin  // blip, high
                w_rom_vco   = 12'd800;
                w_rom_mix   = 3'd1;
                w_rom_dur   = 10'd20;
            end
            default: ;
        endcase
    end

    // Sweep arithmetic with clamping to the 12-bit range instead of wrapping
    assign w_vco_sum = $signed({2'b00, vco_freq}) + $signed({{4{r_delta[9]}}, r_delta});
    always_comb begin
        w_vco_sat = w_vco_sum[11:0];
        if (w_vco_sum < 14'sd0)
            w_vco_sat = 12'd0;
        else if (w_vco_sum > 14'sd4095)
            w_vco_sat = 12'd4095;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_st_idle;
        else
            r_state <= w_state_next;
    end

    // Next-state and step-control decode; retrigger wins over a step end
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_sweep      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (trigger) begin
                    w_load       = 1'b1;
                    w_state_next = c_st_play;
                end
            end
            c_st_play: begin
                if (trigger) begin
                    w_load = 1'b1;
                end else if (w_tick) begin
                    if (r_dur_cnt == 10'd0) begin
                        if (r_last) begin
                            w_finish     = 1'b1;
                            w_state_next = c_st_idle;
                        end else begin
                            w_load = 1'b1;
                        end
                    end else begin
                        w_sweep = 1'b1;
                    end
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Step datapath: load ROM fields, run tick/duration counters, apply sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt   <= '0;
            r_dur_cnt    <= 10'd0;
            r_step       <= 2'd0;
            r_effect     <= 2'd0;
            r_delta      <= 10'd0;
            r_last       <= 1'b0;
            r_done       <= 1'b0;
            vco_freq     <= 12'd0;
            noise_freq   <= 12'd0;
            lfo_freq     <= 12'd0;
            vco_select   <= 1'b0;
            noise_select <= 1'b0;
            lfo_shift    <= 4'd0;
            mixer        <= 3'd0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_tick_cnt   <= '0;
                r_dur_cnt    <= w_rom_dur - 10'd1;
                r_step       <= w_rom_step;
                r_effect     <= w_rom_eff;
                r_delta      <= w_rom_delta;
                r_last       <= w_rom_last;
                vco_freq     <= w_rom_vco;
                noise_freq   <= w_rom_noise;
                lfo_freq     <= w_rom_lfo;
                vco_select   <= w_rom_vsel;
                noise_select <= w_rom_nsel;
                lfo_shift    <= w_rom_shift;
                mixer        <= w_rom_mix;
            end else if (r_state == c_st_play) begin
                r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + 1'b1);
                if (w_sweep) begin
                    r_dur_cnt <= r_dur_cnt - 10'd1;
                    vco_freq  <= w_vco_sat;
                end
            end
        end
    end

    assign gate = (r_state == c_st_play);
    assign busy = gate;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sfx_sequencer
//  Purpose  : Self-checking bench for sfx_sequencer with TICK_DIV=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sfx_sequencer;

    logic        clk = 1'b0;
    logic        reset, trigger, trigger_sat;
    logic [1:0]  effect_sel;
    logic [11:0] lfo_freq, noise_freq, vco_freq;
    logic        vco_select, noise_select, gate, busy, done;
    logic [3:0]  lfo_shift;
    logic [2:0]  mixer;

    logic [11:0] s_lfo, s_noise, s_vco;
    logic        s_vsel, s_nsel, s_gate, s_busy, s_done;
    logic [3:0]  s_shift;
    logic [2:0]  s_mix;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sfx_sequencer #(.TICK_DIV(4), .LASER_DUR(80)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .effect_sel(effect_sel),
        .lfo_freq(lfo_freq), .noise_freq(noise_freq), .vco_freq(vco_freq),
        .vco_select(vco_select), .noise_select(noise_select),
        .lfo_shift(lfo_shift), .mixer(mixer), .gate(gate), .busy(busy), .done(done)
    );

    // Laser with a long step so the downward sweep runs past zero
    sfx_sequencer #(.TICK_DIV(4), .LASER_DUR(120)) dut_sat (
        .clk(clk), .reset(reset), .trigger(trigger_sat), .effect_sel(effect_sel),
        .lfo_freq(s_lfo), .noise_freq(s_noise), .vco_freq(s_vco),
        .vco_select(s_vsel), .noise_select(s_nsel),
        .lfo_shift(s_shift), .mixer(s_mix), .gate(s_gate), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        int sel;
        int k;      // cycles after the start edge at which to sample
        int vco;
        int noise;
        int lfo;
        int vsel;
        int nsel;
        int shift;
        int mix;
        int gate;
        int done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at the negedge right after the edge that sampled the trigger
    task automatic start(input int sel);
        @(negedge clk);
        trigger    = 1'b1;
        effect_sel = 2'(sel);
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " vco_freq"},     int'(vco_freq),     v.vco);
        chk({tag, " noise_freq"},   int'(noise_freq),   v.noise);
        chk({tag, " lfo_freq"},     int'(lfo_freq),     v.lfo);
        chk({tag, " vco_select"},   int'(vco_select),   v.vsel);
        chk({tag, " noise_select"}, int'(noise_select), v.nsel);
        chk({tag, " lfo_shift"},    int'(lfo_shift),    v.shift);
        chk({tag, " mixer"},        int'(mixer),        v.mix);
        chk({tag, " gate"},         int'(gate),         v.gate);
        chk({tag, " busy"},         int'(busy),         v.gate);
        chk({tag, " done"},         int'(done),         v.done);
    endtask

    initial begin
        int dones, busy_cyc, exp_vco;
        vec_t zero;

        reset = 1'b1; trigger = 1'b0; trigger_sat = 1'b0; effect_sel = 2'd0;
        zero = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        //            sel  k    vco  noise lfo  vs ns sh mx g  d
        vecs.push_back('{0, 0,    800, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 3,    800, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 4,    792, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 8,    784, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 319,  168, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 320,  168, 0,   0,    0, 0, 0, 1, 0, 1});
        vecs.push_back('{0, 321,  168, 0,   0,    0, 0, 0, 1, 0, 0});
        vecs.push_back('{1, 0,    0,   90,  0,    0, 1, 0, 2, 1, 0});
        vecs.push_back('{1, 799,  0,   90,  0,    0, 1, 0, 2, 1, 0});
        vecs.push_back('{1, 800,  0,   200, 0,    0, 1, 0, 2, 1, 0});
        vecs.push_back('{1, 1999, 0,   200, 0,    0, 1, 0, 2, 1, 0});
        vecs.push_back('{1, 2000, 0,   200, 0,    0, 1, 0, 2, 0, 1});
        vecs.push_back('{2, 0,    250, 0,   1000, 1, 0, 1, 1, 1, 0});
        vecs.push_back('{3, 0,    400, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{3, 79,   400, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{3, 80,   600, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{3, 159,  600, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{3, 160,  800, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{3, 239,  800, 0,   0,    0, 0, 0, 1, 1, 0});
        vecs.push_back('{3, 240,  800, 0,   0,    0, 0, 0, 1, 0, 1});

        // Reset state
        wait_cyc(2);
        reset = 1'b0;
        @(negedge clk);
        chk_all("reset", zero);

        // Table-driven: fresh reset, trigger, sample k cycles later
        foreach (vecs[i]) begin
            do_reset();
            start(vecs[i].sel);
            wait_cyc(vecs[i].k);
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Explosion: busy length and exactly one done pulse
        do_reset();
        start(1);
        dones = 0; busy_cyc = 0;
        for (int c = 0; c < 2100; c++) begin
            if (busy) busy_cyc++;
            if (done) dones++;
            @(negedge clk);
        end
        chk("expl busy_cycles", busy_cyc, 2000);
        chk("expl done_count", dones, 1);

        // Blip: gate continuous for 240 cycles
        do_reset();
        start(3);
        busy_cyc = 0;
        for (int c = 0; c < 300; c++) begin
            if (gate) busy_cyc++;
            @(negedge clk);
        end
        chk("blip gate_cycles", busy_cyc, 240);

        // Retrigger siren -> laser
        do_reset();
        start(2);
        dones = 0;
        for (int c = 0; c < 100; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        start(0);
        chk("retrig vco_freq", int'(vco_freq), 800);
        chk("retrig lfo_freq", int'(lfo_freq), 0);
        chk("retrig vco_select", int'(vco_select), 0);
        chk("retrig gate", int'(gate), 1);
        for (int c = 0; c < 320; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("retrig early_done", dones, 0);
        chk("retrig done_at_320", int'(done), 1);
        chk("retrig gate_at_320", int'(gate), 0);

        // Reset during explosion step 1, then a clean replay
        do_reset();
        start(1);
        dones = 0;
        for (int c = 0; c < 900; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("midrst step1_noise", int'(noise_freq), 200);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all("midrst", zero);
        for (int c = 0; c < 2100; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("midrst done_count", dones, 0);
        start(1);
        chk("replay noise_freq", int'(noise_freq), 90);
        chk("replay gate", int'(gate), 1);
        wait_cyc(2000);
        chk("replay done", int'(done), 1);

        // Sweep saturation on the long-laser instance
        do_reset();
        @(negedge clk);
        trigger_sat = 1'b1;
        effect_sel  = 2'd0;
        @(negedge clk);
        trigger_sat = 1'b0;
        for (int k = 0; k < 480; k += 4) begin
            exp_vco = 800 - 8 * (k / 4);
            if (exp_vco < 0) exp_vco = 0;
            chk($sformatf("sat vco k=%0d", k), int'(s_vco), exp_vco);
            wait_cyc(4);
        end
        chk("sat done", int'(s_done), 1);
        chk("sat final_vco", int'(s_vco), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Upstream control stage for the SN76477 sound core.
- On a trigger, it plays a canned sound effect: a short sequence of timed steps from an internal ROM.
- Each step drives the SN76477 parameter inputs, with an optional linear VCO sweep.
- A gate output lets the top level mute the speaker between effects.

Parameters:
- TICK_DIV, 25000, clk cycles per sequencer tick (1 ms at 25 MHz).

Ports:
- clk  input  1  system clock (25 MHz in the sound design)
- reset  input  1  synchronous, active-high reset
- trigger  input  1  one-cycle start request
- effect_sel  input  2  effect index, sampled when trigger=1
- lfo_freq  output  12  to SN76477 lfo_freq
- noise_freq  output  12  to SN76477 noise_freq
- vco_freq  output  12  to SN76477 vco_freq
- vco_select  output  1  to SN76477
- noise_select  output  1  to SN76477
- lfo_shift  output  4  to SN76477
- mixer  output  3  to SN76477
- gate  output  1  1 while an effect plays; top ANDs it with spkr
- busy  output  1  equals gate
- done  output  1  one-cycle pulse when an effect completes naturally

Behaviour:
- Clock and reset: single clock, synchronous active-high reset.
- Reset values: state IDLE; all parameter outputs 0; gate, busy and done 0; tick and step counters 0.
- States:
  - IDLE: outputs hold their last values; gate=0.
  - PLAY: step active; gate=1.
  - No separate load state; the step load happens in the transition cycle.
- Start: trigger=1 at clock edge N latches effect_sel, loads step 0 and enters PLAY.
  - Outputs reflect step 0 and gate=1 after edge N (1-cycle latency).
- Step timing:
  - Each step lasts exactly dur×TICK_DIV cycles.
  - tick_cnt counts 0..TICK_DIV-1; a tick occurs when it wraps.
  - dur_cnt decrements on each tick; the step ends on the tick where dur_cnt reaches 0.
  - Both counters restart on every step load.
- Sweep: on each tick inside a step (not on the final tick), vco_freq += delta (signed 10-bit).
  - Saturate at 0 and 4095; no wrap-around.
- Step end:
  - If last=0: load step+1 on the same edge; no gap cycle.
  - If last=1: go to IDLE, gate=0, and pulse done=1 for one cycle.
- Retrigger: trigger while in PLAY restarts at step 0 of the newly sampled effect_sel.
  - No done pulse is produced.
  - Counters restart.
  - Retrigger takes priority over a simultaneous natural step end.
- Reset mid-effect: the reset values apply on the next edge; done is not pulsed.
- ROM fields per step: vco, delta, noise, lfo, vsel, nsel, shift, mix, dur, last.
  - Steps listed as (vco, delta, noise, lfo, vsel, nsel, shift, mix, dur, last).
  - Effect 0 laser: S0 = (800, -8, 0, 0, 0, 0, 0, 1, 80, 1).
  - Effect 1 explosion: S0 = (0, 0, 90, 0, 0, 1, 0, 2, 200, 0); S1 = (0, 0, 200, 0, 0, 1, 0, 2, 300, 1).
  - Effect 2 siren: S0 = (250, 0, 0, 1000, 1, 0, 1, 1, 500, 1).
  - Effect 3 blip: S0 = (400, 0, 0, 0, 0, 0, 0, 1, 20, 0); S1 = (600, 0, …, 1, 20, 0); S2 = (800, 0, …, 1, 20, 1).
  - Fields not listed in S1/S2 are 0.
- Counter widths: dur is 10 bits; tick_cnt is sized by $clog2(TICK_DIV).

Test Plan:
(All scenarios use TICK_DIV=4.)
- Laser timing and sweep:
  - Stimulus: reset, then trigger with sel=0.
  - Required: next cycle vco_freq=800, mixer=1, gate=1.
  - Required: vco_freq is 792 after 4 cycles and decrements by 8 every 4 cycles.
  - Required: gate falls and done pulses exactly 320 cycles after the start edge; last vco_freq=800-79×8=168.
- Explosion step chaining:
  - Stimulus: trigger with sel=1.
  - Required: noise_freq=90, noise_select=1 for 800 cycles, then noise_freq=200 with no gap.
  - Required: total busy duration is 2000 cycles, followed by a single done pulse.
- Blip three-step sequence:
  - Stimulus: trigger with sel=3.
  - Required: vco_freq is 400, 600, 800, each held 80 cycles; gate is continuous for 240 cycles.
- Retrigger:
  - Stimulus: trigger sel=2, then 100 cycles later trigger sel=0.
  - Required: the next cycle shows vco_freq=800, lfo_freq=0, vco_select=0.
  - Required: no done pulse at the retrigger; done comes 320 cycles after the second trigger.
- Reset mid-effect:
  - Stimulus: assert reset during explosion step 1.
  - Required: next cycle all outputs are 0 and gate=0; done is never pulsed.
  - Required: a subsequent trigger with sel=1 plays normally.
- Sweep saturation:
  - Stimulus: force laser with a ROM override or long dur in a test variant so vco drops below 0.
  - Required: vco_freq holds 0 and does not wrap to 4088.
